regfile_writeback_queue: RTL and testbench

REGFILE_WRITEBACK_QUEUE -- requirements
Module: regfile_writeback_queue

---
 rtl/riscv_pkg.sv | 12 +
 rtl/wb_fwd_match.sv | 35 +++
 rtl/regfile_writeback_queue.sv | 89 ++++++++
 tb/tb_regfile_writeback_queue.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core-wide widths and the writeback entry bundle.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search of queued writebacks for one register read port.
module wb_fwd_match
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [PW-1:0]         head,
    input  logic [CW-1:0]         occupancy,
    input  logic [REG_ADDR_W-1:0] lookup_reg,
    output logic                  hit,
    output logic [XLEN-1:0]       data
);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < occupancy) &&
                (lookup_reg != '0) &&
                (entries[idx].rd == lookup_reg)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback FIFO owning the register file write port, with read forwarding.
module regfile_writeback_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]       in_data,
    input  logic                  drain_en,
    output logic                  rf_regwrite,
    output logic [REG_ADDR_W-1:0] rf_write_reg,
    output logic [XLEN-1:0]       rf_write_data,
    input  logic [REG_ADDR_W-1:0] lookup_reg1,
    input  logic [REG_ADDR_W-1:0] lookup_reg2,
    output logic                  fwd_hit1,
    output logic [XLEN-1:0]       fwd_data1,
    output logic                  fwd_hit2,
    output logic [XLEN-1:0]       fwd_data2,
    output logic [CW-1:0]         count
);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  not_empty;

    assign not_empty = (count != '0);
    assign in_ready  = (count < CW'(DEPTH));
    // x0 offers are consumed but never stored.
    assign push      = in_valid && in_ready &&
                       (in_rd != '0);
    assign pop       = not_empty && drain_en;

    assign rf_regwrite   = pop;
    assign rf_write_reg  = not_empty ?
                           mem[rd_ptr].rd : '0;
    assign rf_write_data = not_empty ?
                           mem[rd_ptr].data : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr].rd   <= in_rd;
            mem[wr_ptr].data <= in_data;
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries    (mem),
        .head       (rd_ptr),
        .occupancy  (count),
        .lookup_reg (lookup_reg1),
        .hit        (fwd_hit1),
        .data       (fwd_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries    (mem),
        .head       (rd_ptr),
        .occupancy  (count),
        .lookup_reg (lookup_reg2),
        .hit        (fwd_hit2),
        .data       (fwd_data2)
    );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench: vector table, directed corners, random vs queue model.
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        drain_en;
    logic        rf_regwrite;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [4:0]  lookup_reg1;
    logic [4:0]  lookup_reg2;
    logic        fwd_hit1;
    logic [31:0] fwd_data1;
    logic        fwd_hit2;
    logic [31:0] fwd_data2;
    logic [2:0]  count;

    regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_data       (in_data),
        .drain_en      (drain_en),
        .rf_regwrite   (rf_regwrite),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .lookup_reg1   (lookup_reg1),
        .lookup_reg2   (lookup_reg2),
        .fwd_hit1      (fwd_hit1),
        .fwd_data1     (fwd_data1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data2     (fwd_data2),
        .count         (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        bit          v;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          dr;
        logic [4:0]  l1;
        bit          e_we;
        logic [4:0]  e_reg;
        logic [31:0] e_wdata;
        bit          e_hit1;
        logic [31:0] e_d1;
        int          e_cnt;
    } vec_t;

    ent_t mq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h",
                     nm, act, exp);
        end
    endtask

    task automatic apply(bit v, logic [4:0] rd,
                         logic [31:0] d, bit dr,
                         logic [4:0] a1, logic [4:0] a2);
        in_valid    = v;
        in_rd       = rd;
        in_data     = d;
        drain_en    = dr;
        lookup_reg1 = a1;
        lookup_reg2 = a2;
        #3;
    endtask

    // Search from the back of the queue: youngest match wins.
    task automatic model_fwd(logic [4:0] r, output bit h,
                             output logic [31:0] d);
        h = 0;
        d = '0;
        if (r != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!h && mq[i].rd == r) begin
                    h = 1;
                    d = mq[i].data;
                end
            end
        end
    endtask

    task automatic check_model(string tag);
        bit          h1, h2;
        logic [31:0] d1, d2;
        int          n;
        n = mq.size();
        model_fwd(lookup_reg1, h1, d1);
        model_fwd(lookup_reg2, h2, d2);
        chk({tag, " count"}, 32'(count), 32'(n));
        chk({tag, " in_ready"}, 32'(in_ready),
            32'(n < DEPTH));
        chk({tag, " regwrite"}, 32'(rf_regwrite),
            32'(n != 0 && drain_en));
        chk({tag, " wreg"}, 32'(rf_write_reg),
            n != 0 ? 32'(mq[0].rd) : 32'd0);
        chk({tag, " wdata"}, rf_write_data,
            n != 0 ? mq[0].data : 32'd0);
        chk({tag, " hit1"}, 32'(fwd_hit1), 32'(h1));
        chk({tag, " data1"}, fwd_data1, d1);
        chk({tag, " hit2"}, 32'(fwd_hit2), 32'(h2));
        chk({tag, " data2"}, fwd_data2, d2);
    endtask

    task automatic step();
        bit   mpush, mpop;
        ent_t e;
        mpop  = (mq.size() != 0) && drain_en;
        mpush = in_valid && (mq.size() < DEPTH) &&
                (in_rd != 0);
        e.rd   = in_rd;
        e.data = in_data;
        @(posedge clock);
        if (mpop)  void'(mq.pop_front());
        if (mpush) mq.push_back(e);
        #1;
    endtask

    task automatic cyc(string tag, bit v, logic [4:0] rd,
                       logic [31:0] d, bit dr,
                       logic [4:0] a1, logic [4:0] a2);
        apply(v, rd, d, dr, a1, a2);
        check_model(tag);
        step();
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 5, 32'hDEADBEEF, 1, 5,
                   0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 1, 5,
                   1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1};
        tbl[2] = '{0, 0, 0, 0, 5,
                   0, 0, 0, 0, 0, 0};
        tbl[3] = '{1, 0, 32'hFFFF, 1, 0,
                   0, 0, 0, 0, 0, 0};
        tbl[4] = '{1, 7, 32'h11, 0, 0,
                   0, 0, 0, 0, 0, 0};
        tbl[5] = '{1, 7, 32'h22, 0, 7,
                   0, 7, 32'h11, 1, 32'h11, 1};
        tbl[6] = '{0, 0, 0, 0, 7,
                   0, 7, 32'h11, 1, 32'h22, 2};
        tbl[7] = '{0, 0, 0, 1, 7,
                   1, 7, 32'h11, 1, 32'h22, 2};
        tbl[8] = '{0, 0, 0, 1, 7,
                   1, 7, 32'h22, 1, 32'h22, 1};
        tbl[9] = '{0, 0, 0, 0, 7,
                   0, 0, 0, 0, 0, 0};

        reset = 1'b1;
        apply(1, 3, 32'h1234, 1, 3, 3);
        repeat (2) @(posedge clock);
        #4;
        chk("rst count", 32'(count), 0);
        chk("rst in_ready", 32'(in_ready), 1);
        chk("rst regwrite", 32'(rf_regwrite), 0);
        chk("rst wreg", 32'(rf_write_reg), 0);
        chk("rst wdata", rf_write_data, 0);
        chk("rst hit1", 32'(fwd_hit1), 0);
        chk("rst hit2", 32'(fwd_hit2), 0);
        chk("rst data1", fwd_data1, 0);
        chk("rst data2", fwd_data2, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].v, tbl[i].rd, tbl[i].data,
                  tbl[i].dr, tbl[i].l1, 5'd8);
            chk($sformatf("vec%0d we", i),
                32'(rf_regwrite), 32'(tbl[i].e_we));
            chk($sformatf("vec%0d wreg", i),
                32'(rf_write_reg), 32'(tbl[i].e_reg));
            chk($sformatf("vec%0d wdata", i),
                rf_write_data, tbl[i].e_wdata);
            chk($sformatf("vec%0d hit1", i),
                32'(fwd_hit1), 32'(tbl[i].e_hit1));
            chk($sformatf("vec%0d data1", i),
                fwd_data1, tbl[i].e_d1);
            chk($sformatf("vec%0d hit2", i),
                32'(fwd_hit2), 0);
            chk($sformatf("vec%0d count", i),
                32'(count), 32'(tbl[i].e_cnt));
            check_model($sformatf("vec%0d", i));
            step();
        end

        for (int i = 1; i <= 4; i++)
            cyc("fill", 1, 5'(i), 32'(100 + i), 0, 2, 4);
        apply(1, 9, 32'h999, 0, 9, 1);
        chk("full count", 32'(count), 4);
        chk("full in_ready", 32'(in_ready), 0);
        check_model("full");
        step();
        chk("no 5th count", 32'(count), 4);
        for (int i = 1; i <= 4; i++) begin
            apply(0, 0, 0, 1, 9, 3);
            chk("drain we", 32'(rf_regwrite), 1);
            chk("drain order", 32'(rf_write_reg), 32'(i));
            chk("drain data", rf_write_data, 32'(100 + i));
            check_model("drain");
            step();
        end
        chk("drained", 32'(count), 0);

        cyc("pp pre", 1, 10, 32'hA0, 0, 10, 11);
        cyc("pp pre", 1, 11, 32'hA1, 0, 10, 11);
        for (int i = 0; i < 12; i++) begin
            apply(1, 5'(12 + i), 32'hB00 + 32'(i), 1,
                  5'(12 + i), 5'(11 + i));
            chk("pp count", 32'(count), 2);
            check_model("pp");
            step();
        end
        chk("pp after", 32'(count), 2);

        for (int i = 0; i < 3; i++)
            cyc("prerst", 1, 5'(20 + i), 32'(i), 0, 20, 21);
        in_valid = 1'b0;
        drain_en = 1'b1;
        lookup_reg1 = 5'd20;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst count", 32'(count), 0);
        chk("midrst we", 32'(rf_regwrite), 0);
        chk("midrst hit1", 32'(fwd_hit1), 0);
        mq.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 0, 1, 21, 22);
            chk("stale we", 32'(rf_regwrite), 0);
            check_model("postrst");
            step();
        end

        for (int i = 0; i < 400; i++) begin
            cyc("rand",
                $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 7)),
                $urandom,
                $urandom_range(0, 2) != 0,
                5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

endmodule
